// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: bus widths, enable levels
// and the controller state type.
package icache_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic {
        IDLE,
        MISS
    } icache_state_e;

    function automatic int unsigned cache_lines(input int unsigned index_w);
        return 32'd1 << index_w;
    endfunction

    function automatic int unsigned cache_tag_w(input int unsigned index_w);
        return ADDR_W - index_w - 2;
    endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines: answers hits in one
// cycle and refills misses from memory through a single outstanding request.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_S,
    input  logic [31:0] IF_pc,
    output logic        IF_success,
    output logic [31:0] IF_value,
    output logic        Mem_S,
    output logic [31:0] Mem_pc,
    input  logic        Mem_success,
    input  logic [31:0] Mem_value,
    input  logic        ROB_Jump_S
);

    localparam int LINES = int'(cache_lines(INDEX_W));
    localparam int TAG_W = int'(cache_tag_w(INDEX_W));

    icache_state_e state_q, state_d;
    logic          abort_q, abort_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          mem_s_q, mem_s_d;
    logic [31:0]   mem_pc_q, mem_pc_d;
    logic          if_success_q, if_success_d;
    logic [31:0]   if_value_q, if_value_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];

    logic [INDEX_W-1:0] if_index;
    logic [TAG_W-1:0]   if_tag;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               mem_done;
    logic               fill_we;
    logic               unused_pc_bits;

    assign if_index   = IF_pc[INDEX_W+1:2];
    assign if_tag     = IF_pc[31:INDEX_W+2];
    assign fill_index = req_pc_q[INDEX_W+1:2];
    assign fill_tag   = req_pc_q[31:INDEX_W+2];
    assign hit        = valid_q[if_index] && (tag_q[if_index] == if_tag);

    // A returning fill completes even under a flush; only a stall holds it off.
    assign mem_done   = (state_q == MISS) && Mem_success && (ROB_Jump_S || rdy);

    assign unused_pc_bits = ^{IF_pc[1:0], req_pc_q[1:0]};

    always_comb begin
        state_d      = state_q;
        abort_d      = abort_q;
        req_pc_d     = req_pc_q;
        mem_s_d      = mem_s_q;
        mem_pc_d     = mem_pc_q;
        if_success_d = DISABLE;
        if_value_d   = if_value_q;
        fill_we      = DISABLE;

        if (mem_done) begin
            fill_we      = ENABLE;
            mem_s_d      = DISABLE;
            state_d      = IDLE;
            abort_d      = DISABLE;
            if_value_d   = Mem_value;
            if_success_d = !(abort_q || ROB_Jump_S);
        end else if (ROB_Jump_S) begin
            if (state_q == MISS) begin
                abort_d = ENABLE;
            end
        end else if (rdy && state_q == IDLE && IF_S && !if_success_q) begin
            // The request still high during a success pulse is the one just answered.
            if (hit) begin
                if_success_d = ENABLE;
                if_value_d   = data_q[if_index];
            end else begin
                req_pc_d = IF_pc;
                mem_s_d  = ENABLE;
                mem_pc_d = IF_pc;
                state_d  = MISS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            abort_q      <= DISABLE;
            req_pc_q     <= '0;
            mem_s_q      <= DISABLE;
            mem_pc_q     <= '0;
            if_success_q <= DISABLE;
            if_value_q   <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            abort_q      <= abort_d;
            req_pc_q     <= req_pc_d;
            mem_s_q      <= mem_s_d;
            mem_pc_q     <= mem_pc_d;
            if_success_q <= if_success_d;
            if_value_q   <= if_value_d;
            if (fill_we) begin
                valid_q[fill_index] <= ENABLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= Mem_value;
        end
    end

    assign IF_success = if_success_q;
    assign IF_value   = if_value_q;
    assign Mem_S      = mem_s_q;
    assign Mem_pc     = mem_pc_q;

endmodule

// File: tb/tb_icache.sv
// Directed and randomized checks of icache against a line-by-pc reference
// model and a fixed memory image.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        IF_S;
    logic [31:0] IF_pc;
    logic        IF_success;
    logic [31:0] IF_value;
    logic        Mem_S;
    logic [31:0] Mem_pc;
    logic        Mem_success;
    logic [31:0] Mem_value;
    logic        ROB_Jump_S;

    int checks = 0;
    int errors = 0;

    bit          refValid [256];
    logic [31:0] refPc    [256];
    logic [31:0] memImage [logic [31:0]];

    always #5 clk = ~clk;

    icache #(.INDEX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .IF_S       (IF_S),
        .IF_pc      (IF_pc),
        .IF_success (IF_success),
        .IF_value   (IF_value),
        .Mem_S      (Mem_S),
        .Mem_pc     (Mem_pc),
        .Mem_success(Mem_success),
        .Mem_value  (Mem_value),
        .ROB_Jump_S (ROB_Jump_S)
    );

    function automatic logic [31:0] memWord(input logic [31:0] pc);
        if (memImage.exists(pc)) return memImage[pc];
        return (pc * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic int lineOf(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hFF);
    endfunction

    function automatic bit refHit(input logic [31:0] pc);
        return refValid[lineOf(pc)] && (refPc[lineOf(pc)] == pc);
    endfunction

    task automatic refFill(input logic [31:0] pc);
        refValid[lineOf(pc)] = 1'b1;
        refPc[lineOf(pc)]    = pc;
    endtask

    task automatic refClear();
        for (int i = 0; i < 256; i++) refValid[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One complete fetch: hit or refill decided by the model, optional flush mid-miss.
    task automatic applyStimulus(input logic [31:0] pc, input bit jumpInMiss);
        bit expHit;
        bit jumped;
        int lat;
        expHit = refHit(pc);
        jumped = 1'b0;
        IF_S   = 1'b1;
        IF_pc  = pc;
        step();
        if (expHit) begin
            checkOutput("hit_pulse", IF_success, 1);
            checkOutput("hit_value", IF_value, memWord(pc));
            checkOutput("hit_no_mem", Mem_S, 0);
        end else begin
            checkOutput("miss_no_pulse", IF_success, 0);
            checkOutput("miss_mem_s", Mem_S, 1);
            checkOutput("miss_mem_pc", Mem_pc, pc);
            IF_pc = $urandom;
            lat = $urandom_range(0, 3);
            for (int i = 0; i < lat; i++) begin
                if (jumpInMiss && i == 0) begin
                    ROB_Jump_S = 1'b1;
                    IF_S       = 1'b0;
                    jumped     = 1'b1;
                end
                step();
                ROB_Jump_S = 1'b0;
                checkOutput("miss_hold_s", Mem_S, 1);
                checkOutput("miss_hold_pc", Mem_pc, pc);
                checkOutput("miss_wait_pulse", IF_success, 0);
            end
            if (jumpInMiss && lat == 0) begin
                ROB_Jump_S = 1'b1;
                IF_S       = 1'b0;
                jumped     = 1'b1;
            end
            Mem_success = 1'b1;
            Mem_value   = memWord(pc);
            step();
            Mem_success = 1'b0;
            Mem_value   = $urandom;
            ROB_Jump_S  = 1'b0;
            refFill(pc);
            if (jumped) begin
                checkOutput("abort_no_pulse", IF_success, 0);
            end else begin
                checkOutput("fill_pulse", IF_success, 1);
                checkOutput("fill_value", IF_value, memWord(pc));
            end
            checkOutput("fill_mem_s", Mem_S, 0);
        end
        if (IF_S) begin
            step();
            checkOutput("no_double", IF_success, 0);
            checkOutput("no_double_mem", Mem_S, 0);
        end
        IF_S  = 1'b0;
        IF_pc = $urandom;
    endtask

    initial begin
        logic [31:0] pc;
        rst         = 1'b1;
        rdy         = 1'b1;
        IF_S        = 1'b0;
        IF_pc       = '0;
        Mem_success = 1'b0;
        Mem_value   = '0;
        ROB_Jump_S  = 1'b0;
        refClear();
        memImage[32'h0]   = 32'h00000013;
        memImage[32'h400] = 32'hDEADBEEF;
        memImage[32'h8]   = 32'h12345678;

        step();
        step();
        checkOutput("rst_if_success", IF_success, 0);
        checkOutput("rst_if_value", IF_value, 0);
        checkOutput("rst_mem_s", Mem_S, 0);
        checkOutput("rst_mem_pc", Mem_pc, 0);
        rst = 1'b0;
        step();

        $display("[TB] cold miss, hit, conflict");
        applyStimulus(32'h0, 1'b0);
        applyStimulus(32'h0, 1'b0);
        applyStimulus(32'h400, 1'b0);
        applyStimulus(32'h0, 1'b0);

        $display("[TB] flush during miss");
        applyStimulus(32'h8, 1'b1);
        applyStimulus(32'h8, 1'b0);

        $display("[TB] flush while idle");
        IF_S       = 1'b1;
        IF_pc      = 32'h10;
        ROB_Jump_S = 1'b1;
        step();
        checkOutput("jump_idle_miss_pulse", IF_success, 0);
        checkOutput("jump_idle_no_mem", Mem_S, 0);
        IF_pc = 32'h8;
        step();
        checkOutput("jump_idle_hit_pulse", IF_success, 0);
        ROB_Jump_S = 1'b0;
        IF_S       = 1'b0;
        step();

        $display("[TB] stall during hit");
        IF_S  = 1'b1;
        IF_pc = 32'h8;
        rdy   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_hit_pulse", IF_success, 0);
        end
        rdy = 1'b1;
        step();
        checkOutput("stall_hit_release", IF_success, 1);
        checkOutput("stall_hit_value", IF_value, 32'h12345678);
        step();
        checkOutput("stall_hit_single", IF_success, 0);
        IF_S = 1'b0;

        $display("[TB] stall during miss");
        IF_S  = 1'b1;
        IF_pc = 32'h20;
        step();
        checkOutput("stall_miss_start", Mem_S, 1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_miss_mem_s", Mem_S, 1);
            checkOutput("stall_miss_mem_pc", Mem_pc, 32'h20);
            checkOutput("stall_miss_pulse", IF_success, 0);
        end
        rdy         = 1'b1;
        Mem_success = 1'b1;
        Mem_value   = memWord(32'h20);
        step();
        Mem_success = 1'b0;
        refFill(32'h20);
        checkOutput("stall_miss_fill", IF_success, 1);
        checkOutput("stall_miss_value", IF_value, memWord(32'h20));
        step();
        checkOutput("stall_miss_single", IF_success, 0);
        IF_S = 1'b0;
        step();

        $display("[TB] reset during miss");
        IF_S  = 1'b1;
        IF_pc = 32'h30;
        step();
        checkOutput("rst_miss_start", Mem_S, 1);
        rst  = 1'b1;
        IF_S = 1'b0;
        step();
        rst = 1'b0;
        refClear();
        checkOutput("rst_miss_mem_s", Mem_S, 0);
        checkOutput("rst_miss_mem_pc", Mem_pc, 0);
        checkOutput("rst_miss_value", IF_value, 0);
        step();
        applyStimulus(32'h0, 1'b0);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 200; n++) begin
            pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2);
            applyStimulus(pc, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
